aes_key_expand_seq: RTL and testbench
=====================================

// Module: aes_key_expand_seq
// PURPOSE
//  Iterative AES-128 key schedule (FIPS-197 §5.2). Computes one round key per cycle.
//  Holds all 11 round keys in a register bank. rk0..rk10 drive the 128-bit 11:1 round-key mux directly.
//  The cipher datapath must not sample the mux until keys_valid=1.
// PARAMETERS
//  NR     10   number of rounds; only 10 (AES-128) is supported; bank depth = NR+1
//  KEY_W  128  key / round-key width; fixed at 128
// PORTS
//  clk         in   1    clock; all state updates on rising edge
//  rst         in   1    asynchronous active-high reset
//  start       in   1    one-cycle request to expand cipher_key; honoured only when busy=0
//  cipher_key  in   128  AES key; [127:120] = first key byte; [127:96] = w0
//  busy        out  1    expansion in progress
//  done        out  1    one-cycle pulse: rk10 is now written
//  keys_valid  out  1    rk0..rk10 are all consistent with the last accepted key
//  rk0..rk10   out  128  round keys 0..10, registered; rkN[127:96] = w[4N]
//  zeroize     in   1    present only with AES_KEY_ZEROIZE_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset: busy=0, done=0, keys_valid=0, rk0..rk10=128'h0, round counter=0, state=IDLE.
//   Reset is honoured at any time, including mid-expansion; no partial key survives it.
//  FSM: IDLE --start--> EXPAND --(cnt==NR write)--> IDLE.
//  Edge E0, start=1 in IDLE:
//   rk0<=cipher_key; cnt<=1; busy<=1; keys_valid<=0.
//  Edge Ei, i=1..10, in EXPAND:
//   rk[i]<=f(rk[i-1],Rcon[i]); cnt<=cnt+1.
//  Key step:
//   t = SubWord(RotWord(w3)) ^ {Rcon[i],24'h0}, with RotWord({a,b,c,d}) = {b,c,d,a}.
//   n0=w0^t; n1=w1^n0; n2=w2^n1; n3=w3^n2.
//   All XOR is 32-bit; there is no carry.
//  Edge E10 (cnt==10):
//   rk10 written; busy<=0; done<=1 for exactly one cycle; keys_valid<=1; state<=IDLE.
//   Latency: start sampled at E0 -> done visible after E10 (10 cycles).
//   A new start may be accepted from E11 onward.
//  Busy case: start while busy=1 is ignored. No queueing; cipher_key is not re-sampled.
//  Restart case: start in IDLE with keys_valid=1 clears keys_valid at E0 and fully re-expands.
//   rk1..rk10 keep their old values until overwritten.
//  Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. The counter never wraps past NR.
//  rk outputs are stable whenever busy=0; nothing combinational reaches them from start or cipher_key.
// CONFIGURATION
//  AES_KEY_ZEROIZE_EN defined:
//   The zeroize input exists.
//   zeroize=1 at an edge: rk0..rk10<=0, keys_valid<=0, busy<=0, done<=0, state<=IDLE.
//   zeroize has priority over start and over an in-progress expansion.
//   Expansion aborts with no done pulse.
//  Not defined: the port is absent. Keys persist until reset or overwrite.
// STRUCTURE
//  Package aes_pkg:
//   AES_NR=10; AES_NK=4; RCON[1:10] byte constant table.
//   typedef logic [127:0] aes_block_t; typedef logic [31:0] aes_word_t.
//   SBOX 256x8 table, shared with the SubBytes stage.
//  Sub-module aes_sbox: 8-bit combinational S-box lookup, instantiated 4x for SubWord.
//  FSM, counter, Rcon select and bank writes stay in this module.
//  Bank is 11 registers with a write-enable decoded from cnt; no shift chain.
// TESTING
//  FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, start at E0 ->
//   rk1=a0fafe1788542cb123a339392a6c7605.
//   rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
//   done high exactly one cycle after E10.
//  Key 000102030405060708090a0b0c0d0e0f -> rk10=13111d7fe3944a17f307a78b4d2b30c5 (FIPS-197 C.1).
//  Start pulsed at E3 and E7 mid-expansion with a different key ->
//   ignored; A.1 rk10 still produced; a single done pulse.
//  rst asserted at E5 mid-expansion ->
//   all rk=0, busy=0, keys_valid=0 immediately.
//   A fresh start after release gives a correct A.1 result.
//  Back-to-back requests: A.1, then start with the C.1 key at E11 ->
//   keys_valid low E11..E20; C.1 rk10 present after E21.
//  AES_KEY_ZEROIZE_EN: zeroize at E4 ->
//   all rk=0, no done pulse, keys_valid=0, next start accepted.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, round-constant and S-box tables, shared types
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_NK = 4;

    typedef logic [127:0] aes_block_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic [0:0] {
        KX_IDLE   = 1'b0,
        KX_EXPAND = 1'b1
    } kx_state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational 8-bit AES S-box lookup
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand_seq.sv
// rtl/aes_key_expand_seq.sv - iterative AES-128 key schedule into an 11-entry round-key bank; optional zeroize via AES_KEY_ZEROIZE_EN
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] cipher_key,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic             zeroize,
`endif
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    output logic [KEY_W-1:0] rk0,
    output logic [KEY_W-1:0] rk1,
    output logic [KEY_W-1:0] rk2,
    output logic [KEY_W-1:0] rk3,
    output logic [KEY_W-1:0] rk4,
    output logic [KEY_W-1:0] rk5,
    output logic [KEY_W-1:0] rk6,
    output logic [KEY_W-1:0] rk7,
    output logic [KEY_W-1:0] rk8,
    output logic [KEY_W-1:0] rk9,
    output logic [KEY_W-1:0] rk10
);

    localparam logic [3:0] LAST_CNT = 4'(NR);

    kx_state_t  state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       done_n, kv_n;
    logic       load_key, wr_step;
    logic       zero_req;

    aes_block_t bank [0:NR];
    aes_block_t prev_rk, next_rk;
    logic [7:0] rcon_sel;
    aes_word_t  w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

`ifdef AES_KEY_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    assign zero_req = 1'b0;
`endif

    // The previous round key and its Rcon both come from the counter; no shift chain.
    always_comb begin
        prev_rk  = bank[0];
        rcon_sel = RCON[1];
        for (int i = 1; i <= NR; i++) begin
            if (cnt == 4'(i)) begin
                prev_rk  = bank[i-1];
                rcon_sel = RCON[i];
            end
        end
    end

    assign w0  = prev_rk[127:96];
    assign w1  = prev_rk[95:64];
    assign w2  = prev_rk[63:32];
    assign w3  = prev_rk[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot[8*g +: 8]),
            .dout (sub[8*g +: 8])
        );
    end

    assign t       = sub ^ {rcon_sel, 24'h0};
    assign n0      = w0 ^ t;
    assign n1      = w1 ^ n0;
    assign n2      = w2 ^ n1;
    assign n3      = w3 ^ n2;
    assign next_rk = {n0, n1, n2, n3};

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        done_n   = 1'b0;
        kv_n     = keys_valid;
        load_key = 1'b0;
        wr_step  = 1'b0;
        if (zero_req) begin
            state_n = KX_IDLE;
            cnt_n   = 4'd0;
            kv_n    = 1'b0;
        end else begin
            case (state)
                KX_IDLE: begin
                    if (start) begin
                        state_n  = KX_EXPAND;
                        cnt_n    = 4'd1;
                        kv_n     = 1'b0;
                        load_key = 1'b1;
                    end
                end
                KX_EXPAND: begin
                    wr_step = 1'b1;
                    if (cnt == LAST_CNT) begin
                        state_n = KX_IDLE;
                        cnt_n   = 4'd0;
                        done_n  = 1'b1;
                        kv_n    = 1'b1;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                default: begin
                    state_n = KX_IDLE;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= KX_IDLE;
            cnt        <= 4'd0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            done       <= done_n;
            keys_valid <= kv_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) bank[i] <= '0;
        end else if (zero_req) begin
            for (int i = 0; i <= NR; i++) bank[i] <= '0;
        end else begin
            if (load_key) bank[0] <= cipher_key;
            if (wr_step) begin
                for (int i = 1; i <= NR; i++) begin
                    if (cnt == 4'(i)) bank[i] <= next_rk;
                end
            end
        end
    end

    assign busy = (state == KX_EXPAND);

    assign rk0  = bank[0];
    assign rk1  = bank[1];
    assign rk2  = bank[2];
    assign rk3  = bank[3];
    assign rk4  = bank[4];
    assign rk5  = bank[5];
    assign rk6  = bank[6];
    assign rk7  = bank[7];
    assign rk8  = bank[8];
    assign rk9  = bank[9];
    assign rk10 = bank[10];

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb/tb_aes_key_expand_seq.sv - scoreboard bench for aes_key_expand_seq (zeroize case under AES_KEY_ZEROIZE_EN)
module tb_aes_key_expand_seq;

    localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK1_A   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK10_A  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_C   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1_C   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] RK10_C  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    typedef struct {
        logic [127:0] rk0;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] cipher_key;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif
    logic         busy, done, keys_valid;
    logic [127:0] rk0, rk1, rk2, rk3, rk4, rk5, rk6, rk7, rk8, rk9, rk10;

    exp_t exp_q[$];
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    aes_key_expand_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cipher_key (cipher_key),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk0        (rk0),
        .rk1        (rk1),
        .rk2        (rk2),
        .rk3        (rk3),
        .rk4        (rk4),
        .rk5        (rk5),
        .rk6        (rk6),
        .rk7        (rk7),
        .rk8        (rk8),
        .rk9        (rk9),
        .rk10       (rk10)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rk_or();
        return rk0 | rk1 | rk2 | rk3 | rk4 | rk5 | rk6 | rk7 | rk8 | rk9 | rk10;
    endfunction

    // Called at a falling edge; the request is sampled at the next rising edge.
    task automatic start_key(input logic [127:0] key, input logic [127:0] e1, input logic [127:0] e10);
        exp_t e;
        e.rk0 = key; e.rk1 = e1; e.rk10 = e10;
        start = 1'b1;
        cipher_key = key;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            check_eq("done_width", 128'(prev_done), 128'(0));
            check_eq("sb_pending", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("sb_rk0", rk0, e.rk0);
                check_eq("sb_rk1", rk1, e.rk1);
                check_eq("sb_rk10", rk10, e.rk10);
                check_eq("sb_kv", 128'(keys_valid), 128'(1));
                check_eq("sb_busy", 128'(busy), 128'(0));
            end
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dc;
        rst = 1'b1; start = 1'b0; cipher_key = '0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
        check_eq("rst_kv", 128'(keys_valid), 128'(0));
        check_eq("rst_rk", rk_or(), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 A.1 with latency and pulse-width checks
        start_key(KEY_A, RK1_A, RK10_A);
        check_eq("a1_busy_e0", 128'(busy), 128'(1));
        check_eq("a1_kv_e0", 128'(keys_valid), 128'(0));
        check_eq("a1_rk0_e0", rk0, KEY_A);
        wait_done(n);
        check_eq("a1_latency", 128'(n), 128'(10));
        @(negedge clk);
        check_eq("a1_done_low", 128'(done), 128'(0));
        repeat (3) @(negedge clk);
        check_eq("a1_rk10_hold", rk10, RK10_A);
        check_eq("a1_kv_hold", 128'(keys_valid), 128'(1));

        // FIPS-197 C.1
        start_key(KEY_C, RK1_C, RK10_C);
        wait_done(n);
        check_eq("c1_latency", 128'(n), 128'(10));
        repeat (2) @(negedge clk);

        // start pulses while busy must be ignored
        dc = done_cnt;
        start_key(KEY_A, RK1_A, RK10_A);
        repeat (2) @(negedge clk);
        start = 1'b1; cipher_key = KEY_C;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check_eq("busy_latency", 128'(n), 128'(3));
        repeat (12) @(negedge clk);
        check_eq("busy_one_done", 128'(done_cnt - dc), 128'(1));
        check_eq("busy_rk10", rk10, RK10_A);

        // asynchronous reset mid-expansion
        start_key(KEY_C, RK1_C, RK10_C);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_rk", rk_or(), 128'(0));
        check_eq("mid_rst_busy", 128'(busy), 128'(0));
        check_eq("mid_rst_kv", 128'(keys_valid), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_key(KEY_A, RK1_A, RK10_A);
        wait_done(n);
        check_eq("post_rst_latency", 128'(n), 128'(10));

        // back-to-back: C.1 requested on the first edge after done
        start_key(KEY_C, RK1_C, RK10_C);
        for (int i = 0; i < 10; i++) begin
            check_eq("b2b_kv_low", 128'(keys_valid), 128'(0));
            @(negedge clk);
        end
        check_eq("b2b_done", 128'(done), 128'(1));
        check_eq("b2b_kv_high", 128'(keys_valid), 128'(1));
        check_eq("b2b_rk10", rk10, RK10_C);
        repeat (2) @(negedge clk);

`ifdef AES_KEY_ZEROIZE_EN
        // zeroize aborts an expansion without a done pulse
        dc = done_cnt;
        start_key(KEY_A, RK1_A, RK10_A);
        repeat (3) @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        check_eq("zero_rk", rk_or(), 128'(0));
        check_eq("zero_busy", 128'(busy), 128'(0));
        check_eq("zero_kv", 128'(keys_valid), 128'(0));
        exp_q.delete();
        repeat (14) @(negedge clk);
        check_eq("zero_no_done", 128'(done_cnt - dc), 128'(0));
        start_key(KEY_C, RK1_C, RK10_C);
        wait_done(n);
        check_eq("zero_restart_latency", 128'(n), 128'(10));
        repeat (2) @(negedge clk);
`endif

        check_eq("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
